// File: rtl/wake_filter_pkg.sv
// Shared types and width helpers for the wake_filter decision stage.
package wake_filter_pkg;

    typedef enum logic [1:0] {
        LISTEN   = 2'd0,
        WAKE     = 2'd1,
        COOLDOWN = 2'd2
    } wake_state_t;

    localparam int DEF_NUM_CLASSES  = 2;
    localparam int DEF_WINDOW_LEN   = 4;
    localparam int DEF_HOLD_CYCLES  = 16;
    localparam int DEF_COOLDOWN_LEN = 2;

    // Width able to hold a vote count from 0 to window_len.
    function automatic int count_w(input int window_len);
        return $clog2(window_len + 1);
    endfunction

    function automatic int index_w(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

    function automatic int counter_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/wake_filter_vote_window.sv
// Sliding vote window: WINDOW_LEN-bit hit history plus its running population count.
module wake_vote_window
    import wake_filter_pkg::*;
#(
    parameter int WINDOW_LEN = DEF_WINDOW_LEN
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           shift_i,
    input  logic                           hit_i,
    input  logic                           clear_i,
    output logic [count_w(WINDOW_LEN)-1:0] count_o,
    output logic                           oldest_o
);

    localparam int CW = count_w(WINDOW_LEN);

    logic [WINDOW_LEN-1:0] votes;
    logic [WINDOW_LEN:0]   votes_ext;
    logic [CW-1:0]         count;

    // Concatenate then truncate so a one-entry window needs no special case.
    assign votes_ext = {votes, hit_i};
    assign oldest_o  = votes[WINDOW_LEN-1];
    assign count_o   = count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            votes <= '0;
            count <= '0;
        end else if (shift_i) begin
            votes <= votes_ext[WINDOW_LEN-1:0];
            count <= count + CW'(hit_i) - CW'(oldest_o);
        end
    end

endmodule

// File: rtl/wake_filter.sv
// Wake decision stage: vote window over argmax results, held wake pulse, cooldown.
// Defining WAKE_FILTER_ONEHOT_CHK_EN adds a sticky err_o for non-one-hot inputs.
module wake_filter
    import wake_filter_pkg::*;
#(
    parameter int NUM_CLASSES  = DEF_NUM_CLASSES,
    parameter int WINDOW_LEN   = DEF_WINDOW_LEN,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int COOLDOWN_LEN = DEF_COOLDOWN_LEN
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_CLASSES-1:0]          data_i,
    input  logic                            valid_i,
    input  logic                            last_i,
    output logic                            ready_o,
    input  logic [index_w(NUM_CLASSES)-1:0] target_i,
    input  logic [count_w(WINDOW_LEN)-1:0]  threshold_i,
    output logic                            wake_o,
    output logic                            valid_o,
    output logic [count_w(WINDOW_LEN)-1:0]  count_o
`ifdef WAKE_FILTER_ONEHOT_CHK_EN
    ,
    output logic                            err_o
`endif
);

    localparam int CW = count_w(WINDOW_LEN);
    localparam int HW = counter_w(HOLD_CYCLES);
    localparam int DW = counter_w(COOLDOWN_LEN);

    wake_state_t   state, state_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic [DW-1:0] cool_cnt, cool_next;
    logic [CW-1:0] win_count, new_count, count_q, thr_eff;
    logic          accept, one_hot, hit, fire, clear, oldest, valid_q;

    // valid/ready: a word transfers on a rising edge where valid_i and ready_o are both high;
    // ready_o only drops while reset is being applied.
    assign ready_o = ~rst_i;
    assign accept  = valid_i & ready_o;

    // Shifting past the top bit yields zero, so an out-of-range target is a miss.
    assign one_hot = (data_i != '0) && ((data_i & (data_i - NUM_CLASSES'(1))) == '0);
    assign hit     = one_hot && (|(data_i & (NUM_CLASSES'(1) << target_i)));

    assign new_count = win_count + CW'(hit) - CW'(oldest);
    assign thr_eff   = (threshold_i == '0) ? CW'(1) : threshold_i;
    assign fire      = (state == LISTEN) && accept && (new_count >= thr_eff);
    assign clear     = accept && (fire || last_i);

    wake_vote_window #(
        .WINDOW_LEN(WINDOW_LEN)
    ) u_window (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .shift_i (accept),
        .hit_i   (hit),
        .clear_i (clear),
        .count_o (win_count),
        .oldest_o(oldest)
    );

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        cool_next  = cool_cnt;
        case (state)
            LISTEN: begin
                if (fire) begin
                    state_next = WAKE;
                    hold_next  = HW'(HOLD_CYCLES);
                end
            end
            WAKE: begin
                hold_next = hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) begin
                    if (COOLDOWN_LEN == 0) begin
                        state_next = LISTEN;
                    end else begin
                        state_next = COOLDOWN;
                        cool_next  = DW'(COOLDOWN_LEN);
                    end
                end
            end
            COOLDOWN: begin
                if (accept) begin
                    cool_next = cool_cnt - DW'(1);
                    if (cool_cnt == DW'(1)) state_next = LISTEN;
                end
            end
            default: state_next = LISTEN;
        endcase
    end

    // count_q shows the decision count for one cycle after an accept, then the window count,
    // so a firing or last accept still reports the count it was judged on.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= LISTEN;
            hold_cnt <= '0;
            cool_cnt <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            cool_cnt <= cool_next;
            valid_q  <= accept;
            count_q  <= accept ? new_count : win_count;
        end
    end

    assign wake_o  = (state == WAKE) && !rst_i;
    assign valid_o = valid_q && !rst_i;
    assign count_o = rst_i ? '0 : count_q;

`ifdef WAKE_FILTER_ONEHOT_CHK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept && !one_hot) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_wake_filter.sv
// Self-checking bench for wake_filter: vector table, hand-written corner sequences,
// and randomized traffic scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_wake_filter;

    localparam int NUM = 2;
    localparam int W   = 4;
    localparam int H   = 16;
    localparam int C   = 2;
    localparam int CW  = 3;

    logic          clk         = 1'b0;
    logic          rst_i       = 1'b1;
    logic [1:0]    data_i      = '0;
    logic          valid_i     = 1'b0;
    logic          last_i      = 1'b0;
    logic          target_i    = 1'b0;
    logic [CW-1:0] threshold_i = '0;
    logic          ready_o, wake_o, valid_o;
    logic [CW-1:0] count_o;
`ifdef WAKE_FILTER_ONEHOT_CHK_EN
    logic          err_o;
`endif

    int tests = 0;
    int fails = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    wake_filter #(
        .NUM_CLASSES (NUM),
        .WINDOW_LEN  (W),
        .HOLD_CYCLES (H),
        .COOLDOWN_LEN(C)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .target_i   (target_i),
        .threshold_i(threshold_i),
        .wake_o     (wake_o),
        .valid_o    (valid_o),
        .count_o    (count_o)
`ifdef WAKE_FILTER_ONEHOT_CHK_EN
        ,
        .err_o      (err_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // History of hit flags for the last W accepts; its sum is the vote count.
    int hist[$];
    int hold_left = 0;
    int cd_left   = 0;
    logic [CW+1:0] exp_q[$];   // {wake, valid, count} expected in the following cycle

    function automatic bit model_hit(input logic [1:0] d, input int tgt);
        int ones = 0;
        for (int i = 0; i < NUM; i++) ones += int'(d[i]);
        if (ones != 1 || tgt >= NUM) return 1'b0;
        return d[tgt];
    endfunction

    function automatic int hist_sum();
        int s = 0;
        foreach (hist[i]) s += hist[i];
        return s;
    endfunction

    always @(posedge clk) begin : model
        int cnt;
        int thr;
        bit in_wake, in_cd, fire;
        if (rst_i) begin
            hist.delete();
            hold_left = 0;
            cd_left   = 0;
            exp_q.push_back('0);
        end else begin
            in_wake = hold_left > 0;
            in_cd   = !in_wake && cd_left > 0;
            fire    = 1'b0;
            cnt     = hist_sum();
            if (valid_i) begin
                hist.push_back(int'(model_hit(data_i, int'(target_i))));
                if (hist.size() > W) void'(hist.pop_front());
                cnt = hist_sum();
                thr = (threshold_i == 0) ? 1 : int'(threshold_i);
                if (!in_wake && !in_cd) fire = (cnt >= thr);
                if (in_cd) cd_left--;
                if (fire || last_i) hist.delete();
            end
            if (in_wake) begin
                hold_left--;
                if (hold_left == 0) cd_left = C;
            end
            if (fire) hold_left = H;
            exp_q.push_back({hold_left > 0, valid_i, CW'(cnt)});
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : scoreboard
        logic [CW+1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rst_i) e = '0;
            check("sb_outputs", {wake_o, valid_o, count_o}, e);
            check("sb_ready", ready_o, !rst_i);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic          valid;
        logic [1:0]    data;
        logic          last;
        logic          tgt;
        logic [CW-1:0] thr;
        logic          exp_wake;
        logic          exp_valid;
        logic [CW-1:0] exp_count;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] d, input logic l,
                                input logic t, input int th, input logic ew, input logic ev,
                                input int ec, input logic ee);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.tgt = t; x.thr = CW'(th);
        x.exp_wake = ew; x.exp_valid = ev; x.exp_count = CW'(ec); x.exp_err = ee;
        return x;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic v, input logic [1:0] d, input logic l,
                         input logic t, input logic [CW-1:0] th);
        @(posedge clk);
        #1;
        rst_i = r; valid_i = v; data_i = d; last_i = l; target_i = t; threshold_i = th;
    endtask

    // One vector is sampled on one edge, followed by an idle cycle; results checked mid-cycle.
    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        drive(v.rst, v.valid, v.data, v.last, v.tgt, v.thr);
        drive(1'b0, 1'b0, v.data, 1'b0, v.tgt, v.thr);
        @(negedge clk);
        check($sformatf("vec%0d_wake", idx), wake_o, v.exp_wake);
        check($sformatf("vec%0d_valid", idx), valid_o, v.exp_valid);
        check($sformatf("vec%0d_count", idx), count_o, v.exp_count);
`ifdef WAKE_FILTER_ONEHOT_CHK_EN
        check($sformatf("vec%0d_err", idx), err_o, v.exp_err);
`endif
    endtask

    initial begin
        int n;
        int k;
        // basic fire: 01,10,10,10 with target 1, threshold 3
        vecs.push_back(mk(1, 0, 2'b00, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 1, 3, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 3, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 3, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 3, 1, 1, 3, 0));
        // interleaved hits never reach 3
        vecs.push_back(mk(1, 0, 2'b00, 0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 3, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 1, 3, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 3, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 1, 3, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 3, 0, 1, 2, 0));
        // last_i clears after the decision
        vecs.push_back(mk(1, 0, 2'b00, 0, 1, 4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 4, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 4, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 2'b10, 1, 1, 4, 0, 1, 3, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 4, 0, 1, 1, 0));
        // non-one-hot word is a miss
        vecs.push_back(mk(1, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 0, 0, 1, 0, 1, 0, 1));
        // threshold above window never fires
        vecs.push_back(mk(1, 0, 2'b00, 0, 1, 7, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 7, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 7, 0, 1, 2, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 7, 0, 1, 3, 0));
        vecs.push_back(mk(0, 1, 2'b10, 0, 1, 7, 0, 1, 4, 0));
        // threshold 0 acts as 1
        vecs.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 0, 0, 1, 1, 1, 0));

        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) apply_vec(i);
        // hold length: already in first high cycle
        n = 1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (!wake_o) break;
            n++;
        end
        check("hold_len", n, H);
        check("count_after_wake", count_o, 0);

        for (int i = 5; i < vecs.size(); i++) apply_vec(i);

        // reset mid-wake
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1);
        @(negedge clk);
        check("rst_wake", wake_o, 1'b0);
        check("rst_count", count_o, 0);
        check("rst_ready", ready_o, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1);
        @(negedge clk);
        check("post_rst_wake", wake_o, 1'b0);
        check("post_rst_ready", ready_o, 1'b1);
        vecs.push_back(mk(0, 1, 2'b01, 0, 0, 1, 1, 1, 1, 0));
        apply_vec(vecs.size() - 1);

        // continuous hits: hold, two cooldown accepts, then refire
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'd3);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 3'd3);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (wake_o) break;
            k++;
        end
        check("first_fire_seen", k < 20, 1'b1);
        n = 1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (!wake_o) break;
            n++;
        end
        check("stream_hold_len", n, H);
        n = 1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (wake_o) break;
            n++;
        end
        check("cooldown_gap", n, C + 1);
        check("refire", wake_o, 1'b1);

        // randomized traffic, scored by the model
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0) ? !target_i : target_i,
                  ($urandom_range(0, 15) == 0) ? CW'($urandom_range(0, 7)) : threshold_i);
        end
        drive(1'b0, 1'b0, 2'b00, 1'b0, target_i, threshold_i);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
